// File: rtl/not_bank_test_sequencer.sv
// Self-test sequencer for a WIDTH-bit NOT-gate bank: sweeps every input pattern,
// lets each settle, checks the outputs against the inverted pattern, and reports.
module not_bank_test_sequencer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_fail
);

    localparam int unsigned      CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0] PAT_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dut_a_q, dut_a_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] first_fail_q, first_fail_d;
    logic             fail_seen_q, fail_seen_d;
    logic             mismatch;

    // State register; reset clears every output and the sweep bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dut_a_q      <= '0;
            settle_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dut_a_q      <= dut_a_d;
            settle_cnt_q <= settle_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        dut_a_d      = dut_a_q;
        settle_cnt_d = settle_cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        mismatch     = (dut_y != ~dut_a_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dut_a_d      = '0;
                    settle_cnt_d = '0;
                    err_d        = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                    pass_d       = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_cnt_d = settle_cnt_q + CNT_W'(1);
                if (settle_cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fail_seen_q) begin
                        first_fail_d = dut_a_q;
                        fail_seen_d  = 1'b1;
                    end
                end
                // The final check still counts toward pass, hence mismatch here.
                if (dut_a_q != PAT_LAST) begin
                    dut_a_d      = dut_a_q + WIDTH'(1);
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = !(fail_seen_q || mismatch);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dut_a      = dut_a_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_fail_q;

endmodule
